// File: rtl/instr_fetch_queue_if.sv
// Fetch-to-decode bundle: PC in, program load port, decode handshake out.
// misalign_err exists only when MISALIGN_TRAP_EN is defined.
interface instr_fetch_queue_if #(
  parameter int ADDR_WIDTH  = 6,
  parameter int INSTR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]  pc_in;
  logic                   jmp;
  logic                   load_en;
  logic [ADDR_WIDTH-3:0]  load_addr;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   decode_ready;
  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [ADDR_WIDTH-1:0]  instr_pc;
  logic                   fetch_stall;
`ifdef MISALIGN_TRAP_EN
  logic                   misalign_err;
`endif

`ifdef MISALIGN_TRAP_EN
  modport master (
    output pc_in,
    output jmp,
    output load_en,
    output load_addr,
    output load_data,
    output decode_ready,
    input  instr_valid,
    input  instr_out,
    input  instr_pc,
    input  fetch_stall,
    input  misalign_err
  );

  modport slave (
    input  pc_in,
    input  jmp,
    input  load_en,
    input  load_addr,
    input  load_data,
    input  decode_ready,
    output instr_valid,
    output instr_out,
    output instr_pc,
    output fetch_stall,
    output misalign_err
  );
`else
  modport master (
    output pc_in,
    output jmp,
    output load_en,
    output load_addr,
    output load_data,
    output decode_ready,
    input  instr_valid,
    input  instr_out,
    input  instr_pc,
    input  fetch_stall
  );

  modport slave (
    input  pc_in,
    input  jmp,
    input  load_en,
    input  load_addr,
    input  load_data,
    input  decode_ready,
    output instr_valid,
    output instr_out,
    output instr_pc,
    output fetch_stall
  );
`endif

endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch stage: local instruction memory feeding a 2-entry {pc, word} queue.
// Optional MISALIGN_TRAP_EN adds a sticky misaligned-PC trap.
module instr_fetch_queue #(
  parameter int ADDR_WIDTH  = 6,
  parameter int INSTR_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_queue_if.slave bus
);

  localparam int WA    = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << WA;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] ins;
  } ent_t;

  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
  ent_t                   ent_q [2];
  ent_t                   rd_ent;
  logic [WA-1:0]          rd_idx;

  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;

  logic full;
  logic push;
  logic pop;
  logic fetch_ok;
  logic stall_trap;

  assign rd_idx = bus.pc_in[ADDR_WIDTH-1:2];
  assign rd_ent = {bus.pc_in, mem_q[rd_idx]};

  // Memory survives reset so a preloaded program can be rerun.
  always_ff @(posedge clk) begin
    if (bus.load_en) begin
      mem_q[bus.load_addr] <= bus.load_data;
    end
  end

  assign full = (cnt_q == 2'd2);

  assign bus.fetch_stall = bus.load_en
                         | (full & ~bus.decode_ready)
                         | stall_trap;

  assign fetch_ok = ~bus.jmp & ~bus.load_en & ~bus.fetch_stall;

  assign pop = bus.instr_valid & bus.decode_ready & ~bus.jmp;

`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic bad_pc;

  assign bad_pc     = |bus.pc_in[1:0];
  assign push       = fetch_ok & ~bad_pc;
  assign stall_trap = mis_q;

  always_comb begin
    mis_d = mis_q;
    if (bus.jmp) begin
      mis_d = 1'b0;
    end else if (fetch_ok && bad_pc) begin
      mis_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign bus.misalign_err = mis_q;
`else
  assign push       = fetch_ok;
  assign stall_trap = 1'b0;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (1'b1)
      bus.jmp: begin
        cnt_d  = 2'd0;
        head_d = 1'b0;
        tail_d = 1'b0;
      end
      (push & pop): begin
        head_d = ~head_q;
        tail_d = ~tail_q;
      end
      (push & ~pop): begin
        cnt_d  = cnt_q + 2'd1;
        tail_d = ~tail_q;
      end
      (pop & ~push): begin
        cnt_d  = cnt_q - 2'd1;
        head_d = ~head_q;
      end
      default: ;
    endcase
  end

  // When full with a pop, tail aliases head: the new entry lands in the freed slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      if (push) begin
        ent_q[tail_q] <= rd_ent;
      end
    end
  end

  assign bus.instr_valid = (cnt_q != 2'd0);
  assign bus.instr_out   = ent_q[head_q].ins;
  assign bus.instr_pc    = ent_q[head_q].pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized and directed bench for instr_fetch_queue.
// Reference is a plain queue of {pc, word} plus a memory array.
module tb_instr_fetch_queue;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instr_fetch_queue_if #(.ADDR_WIDTH(6), .INSTR_WIDTH(32)) bus ();

  instr_fetch_queue #(.ADDR_WIDTH(6), .INSTR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [5:0]  pc;
    logic [31:0] ins;
  } me_t;

  logic [31:0] mmem [16];
  me_t         mq [$];
  bit          mmis;
  int          checks = 0;
  int          errors = 0;

  task automatic set(input logic [5:0] pc, input logic rdy, input logic j,
                     input logic ld, input logic [3:0] la,
                     input logic [31:0] ldd);
    bus.pc_in        = pc;
    bus.decode_ready = rdy;
    bus.jmp          = j;
    bus.load_en      = ld;
    bus.load_addr    = la;
    bus.load_data    = ldd;
    #1;
  endtask

  // Advance one clock, applying the architectural rules to the reference.
  task automatic tick();
    bit  stall, pp, ok, bad;
    me_t e;
    stall = bus.load_en || (mq.size() == 2 && !bus.decode_ready) || mmis;
    pp    = mq.size() != 0 && bus.decode_ready;
    ok    = !bus.jmp && !bus.load_en && !stall;
`ifdef MISALIGN_TRAP_EN
    bad   = bus.pc_in[1:0] != 2'b00;
`else
    bad   = 1'b0;
`endif
    e.pc  = bus.pc_in;
    e.ins = mmem[bus.pc_in[5:2]];
    if (rst || bus.jmp) begin
      mq.delete();
      mmis = 1'b0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (ok && !bad) mq.push_back(e);
      if (ok && bad) mmis = 1'b1;
    end
    if (bus.load_en) mmem[bus.load_addr] = bus.load_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set(6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b exp=0", bus.instr_valid);
    end
    checks++;
    if (bus.instr_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_out got=%h exp=0", bus.instr_out);
    end
    checks++;
    if (bus.instr_pc !== 6'd0) begin
      errors++;
      $display("FAIL reset_pc got=%h exp=0", bus.instr_pc);
    end
    checks++;
    if (bus.fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got=%b exp=0", bus.fetch_stall);
    end
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (bus.misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mis got=%b exp=0", bus.misalign_err);
    end
`endif
  endtask

  task automatic test_load();
    logic [31:0] d;
    for (int i = 0; i < 16; i++) begin
      d = (i < 4) ? 32'h11 * (i + 1) : $urandom;
      set(6'd0, 1'b1, 1'b0, 1'b1, i[3:0], d);
      checks++;
      if (bus.fetch_stall !== 1'b1) begin
        errors++;
        $display("FAIL load_stall i=%0d got=%b exp=1", i, bus.fetch_stall);
      end
      tick();
    end
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_nopush got=%b exp=0", bus.instr_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      set(6'(4 * (k % 4)), 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
      if (k > 0) begin
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 6'(4 * (k - 1))
            || bus.instr_out !== 32'h11 * k) begin
          errors++;
          $display("FAIL b2b k=%0d got v=%b pc=%0d ins=%h exp v=1 pc=%0d ins=%h",
                   k, bus.instr_valid, bus.instr_pc, bus.instr_out,
                   4 * (k - 1), 32'h11 * k);
        end
      end
      if (k < 4) tick();
    end
  endtask

  task automatic test_backpressure();
    set(6'd0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
    tick();
    set(6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty got v=%b s=%b exp v=0 s=0",
               bus.instr_valid, bus.fetch_stall);
    end
    tick();
    set(6'd4, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      set(6'd8, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
      checks++;
      if (bus.fetch_stall !== 1'b1 || bus.instr_pc !== 6'd0
          || bus.instr_out !== 32'h11) begin
        errors++;
        $display("FAIL bp_full i=%0d got s=%b pc=%0d ins=%h exp s=1 pc=0 ins=11",
                 i, bus.fetch_stall, bus.instr_pc, bus.instr_out);
      end
      tick();
    end
    set(6'd8, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    checks++;
    if (bus.fetch_stall !== 1'b0 || bus.instr_pc !== 6'd0) begin
      errors++;
      $display("FAIL bp_release got s=%b pc=%0d exp s=0 pc=0",
               bus.fetch_stall, bus.instr_pc);
    end
    tick();
    set(6'd12, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    checks++;
    if (bus.instr_pc !== 6'd4 || bus.instr_out !== 32'h22) begin
      errors++;
      $display("FAIL bp_pop2 got pc=%0d ins=%h exp pc=4 ins=22",
               bus.instr_pc, bus.instr_out);
    end
    tick();
    set(6'd12, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    checks++;
    if (bus.instr_pc !== 6'd8 || bus.instr_out !== 32'h33) begin
      errors++;
      $display("FAIL bp_resume got pc=%0d ins=%h exp pc=8 ins=33",
               bus.instr_pc, bus.instr_out);
    end
  endtask

  task automatic test_jump();
    set(6'd8, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0);
    tick();
    set(6'd40, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL jmp_flush got=%b exp=0", bus.instr_valid);
    end
    tick();
    set(6'd44, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 6'd40
        || bus.instr_out !== mmem[10]) begin
      errors++;
      $display("FAIL jmp_target got v=%b pc=%0d ins=%h exp v=1 pc=40 ins=%h",
               bus.instr_valid, bus.instr_pc, bus.instr_out, mmem[10]);
    end
  endtask

  task automatic test_load_during_fetch();
    logic [31:0] d [3];
    for (int i = 0; i < 3; i++) begin
      d[i] = $urandom;
      set(6'(20 + 4 * i), 1'b1, 1'b0, 1'b1, 4'(5 + i), d[i]);
      checks++;
      if (bus.fetch_stall !== 1'b1) begin
        errors++;
        $display("FAIL ldf_stall i=%0d got=%b exp=1", i, bus.fetch_stall);
      end
      tick();
    end
    set(6'd20, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL ldf_nopush got=%b exp=0", bus.instr_valid);
    end
    tick();
    set(6'd24, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    checks++;
    if (bus.instr_pc !== 6'd20 || bus.instr_out !== d[0]) begin
      errors++;
      $display("FAIL ldf_new got pc=%0d ins=%h exp pc=20 ins=%h",
               bus.instr_pc, bus.instr_out, d[0]);
    end
    tick();
    set(6'd24, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    checks++;
    if (bus.instr_pc !== 6'd24 || bus.instr_out !== d[1]) begin
      errors++;
      $display("FAIL ldf_new2 got pc=%0d ins=%h exp pc=24 ins=%h",
               bus.instr_pc, bus.instr_out, d[1]);
    end
  endtask

  task automatic test_reset_midstream();
    set(6'd4, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set(6'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr_out !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid got v=%b ins=%h exp v=0 ins=0",
               bus.instr_valid, bus.instr_out);
    end
    tick();
    set(6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    checks++;
    if (bus.instr_pc !== 6'd0 || bus.instr_out !== 32'h11) begin
      errors++;
      $display("FAIL rst_mem got pc=%0d ins=%h exp pc=0 ins=11",
               bus.instr_pc, bus.instr_out);
    end
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_misalign();
    set(6'd0, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0);
    tick();
    set(6'd6, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      set(6'd8, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
      checks++;
      if (bus.misalign_err !== 1'b1 || bus.fetch_stall !== 1'b1
          || bus.instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL mis_set i=%0d got m=%b s=%b v=%b exp m=1 s=1 v=0",
                 i, bus.misalign_err, bus.fetch_stall, bus.instr_valid);
      end
      tick();
    end
    set(6'd8, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0);
    tick();
    set(6'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    checks++;
    if (bus.misalign_err !== 1'b0 || bus.fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL mis_clear got m=%b s=%b exp m=0 s=0",
               bus.misalign_err, bus.fetch_stall);
    end
  endtask
`endif

  task automatic test_random();
    bit   ev, es;
    logic [5:0] pc;
    for (int n = 0; n < 600; n++) begin
      pc = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 15) * 4);
      set(pc, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
          $urandom_range(0, 19) == 0, 4'($urandom), $urandom);
      ev = mq.size() != 0;
      es = bus.load_en || (mq.size() == 2 && !bus.decode_ready) || mmis;
      checks++;
      if (bus.instr_valid !== ev) begin
        errors++;
        $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, bus.instr_valid, ev);
      end
      checks++;
      if (bus.fetch_stall !== es) begin
        errors++;
        $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, bus.fetch_stall, es);
      end
      if (ev) begin
        checks++;
        if (bus.instr_pc !== mq[0].pc || bus.instr_out !== mq[0].ins) begin
          errors++;
          $display("FAIL rnd_head n=%0d got pc=%0d ins=%h exp pc=%0d ins=%h",
                   n, bus.instr_pc, bus.instr_out, mq[0].pc, mq[0].ins);
        end
      end
`ifdef MISALIGN_TRAP_EN
      checks++;
      if (bus.misalign_err !== mmis) begin
        errors++;
        $display("FAIL rnd_mis n=%0d got=%b exp=%b", n, bus.misalign_err, mmis);
      end
`endif
      tick();
    end
  endtask

  initial begin
    mmis = 1'b0;
    test_reset();
    test_load();
    test_back_to_back();
    test_backpressure();
    test_jump();
    test_load_during_fetch();
    test_reset_midstream();
`ifdef MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage directly downstream of the program counter.
- Takes the current PC address each cycle and reads a word from a local instruction memory.
- Buffers {pc, instruction} pairs in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Drives a stall back toward the PC, flushes on jump, and provides a load port to preload the program.

Parameters:
ADDR_WIDTH, 6, byte-address width of the PC; memory depth is 2**(ADDR_WIDTH-2) words.
INSTR_WIDTH, 32, instruction word width.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
pc_in  input  ADDR_WIDTH  current PC value (byte address).
jmp  input  1  jump taken this cycle; flushes the queue.
load_en  input  1  instruction memory write enable.
load_addr  input  ADDR_WIDTH-2  word address for the write.
load_data  input  INSTR_WIDTH  word to write.
decode_ready  input  1  decode accepts the head entry.
instr_valid  output  1  queue head is valid.
instr_out  output  INSTR_WIDTH  head instruction.
instr_pc  output  ADDR_WIDTH  PC of the head instruction.
fetch_stall  output  1  PC must hold; the fetch this cycle is not accepted.
misalign_err  output  1  only present when MISALIGN_TRAP_EN is defined (see Optional Feature).

Behaviour:
Clock and reset:
- Single clock clk; reset rst is synchronous and active-high.

Reset:
- Queue count=0; instr_valid=0; instr_out=0; instr_pc=0; misalign_err=0.
- Memory contents are NOT cleared by reset.

Memory:
- 2**(ADDR_WIDTH-2) words (16 at defaults).
- Read is combinational at word index pc_in[ADDR_WIDTH-1:2].
- Write is synchronous: mem[load_addr] <= load_data on a cycle with load_en=1.

Queue:
- 2-entry FIFO of {pc, word} with head/tail pointers and count 0..2.
- Outputs always reflect the head entry: instr_valid = (count != 0).
- When count=0, instr_out and instr_pc hold their last values and are ignored.

Pop:
- Occurs when instr_valid && decode_ready.

Push condition:
- push = !rst && !jmp && !load_en && !fetch_stall.
- Pushes {pc_in, mem[pc_in word]}.

Stall:
- fetch_stall = load_en || (count==2 && !decode_ready). Combinational.
- Full with a simultaneous pop: push is allowed and count stays 2.

Latency:
- PC value at edge N with an empty queue -> instr_valid=1 with that word after edge N+1.
- Sustains 1 instruction/cycle while decode_ready=1.

Jump:
- jmp=1 at an edge: count <= 0, pointers reset, no push that cycle (pc_in is stale).
- A pop in the same cycle is ignored.
- The target at pc_in on the next cycle is fetched normally.

Load during fetch:
- load_en has priority; no push while loading.
- A write to the address being read does not affect the current cycle, because no fetch occurs that cycle.

Simultaneous events:
- Priority: rst > jmp > load_en > normal push/pop.

Address handling:
- pc_in[1:0] are ignored for the memory index.

Optional Feature:
Macro: MISALIGN_TRAP_EN.
- Defined:
  - misalign_err output exists.
  - If a push would occur with pc_in[1:0] != 0, no push occurs; misalign_err <= 1 (sticky).
  - fetch_stall is forced to 1 while misalign_err=1.
  - misalign_err clears only on rst or jmp.
- Undefined:
  - No port, no check.
  - Misaligned PCs fetch the word at pc_in[ADDR_WIDTH-1:2].

Test Plan:
- Reset then load mem[0..3]=0x11,0x22,0x33,0x44 with decode_ready=1; pc_in 0,4,8,12 on consecutive cycles -> instr_valid from cycle+1, with (instr_pc,instr_out) = (0,0x11),(4,0x22),(8,0x33),(12,0x44) back to back.
- decode_ready=0, pc_in 0 then 4 -> count=2, fetch_stall=1, head stays (0,0x11); raise decode_ready -> (0,0x11) then (4,0x22) pop; push resumes in the same cycle.
- Queue holds 2 entries, jmp=1 with pc_in=8 -> next cycle instr_valid=0; pc_in=40 next -> (40, mem[10]) valid one cycle later.
- load_en=1 for 3 cycles while pc_in advances -> fetch_stall=1 each cycle, no pushes; afterwards a fetch of load_addr<<2 returns the new load_data.
- rst asserted with 2 entries queued -> instr_valid=0, instr_out=0 next cycle; a re-fetch of address 0 still returns 0x11 (memory preserved).
- MISALIGN_TRAP_EN defined, pc_in=6 -> misalign_err=1, no push, fetch_stall=1 held; jmp=1 -> misalign_err=0 next cycle.
